// File: rtl/mem_bus_arbiter.sv
// Two-way arbiter sharing one memory port between I-cache and D-cache, with a watchdog on hung slaves.
// Tie-break: ARB_RR_EN defined selects round-robin; undefined selects fixed priority with D winning.
module mem_bus_arbiter #(
    parameter int A_WIDTH   = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic               i_strobe,
    output logic [31:0]        i_din,
    output logic               i_ready,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [31:0]        d_dout,
    input  logic [3:0]         d_wen,
    input  logic [1:0]         d_size,
    input  logic               d_rw,
    input  logic               d_strobe,
    output logic [31:0]        d_din,
    output logic               d_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    output logic               m_rw,
    output logic               m_strobe,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    output logic               bus_err
);
    localparam int CW = $clog2(TO_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [A_WIDTH-1:0] r_m_a;
    logic [31:0]        r_m_din;
    logic [3:0]         r_m_wen;
    logic [1:0]         r_m_size;
    logic               r_m_rw;
    logic               r_m_strobe;
    logic               r_bus_err;
    logic [CW-1:0]      r_cnt;
    logic               w_busy;
    logic               w_expire;
    logic               w_done;
    logic               w_grant_i;
    logic               w_grant_d;

    assign w_busy   = (r_state != S_IDLE);
    // m_ready in the expiry cycle takes precedence, so expiry requires its absence
    assign w_expire = w_busy & r_m_strobe & ~m_ready & (r_cnt == CW'(TO_CYCLES - 1));
    assign w_done   = w_busy & r_m_strobe & (m_ready | w_expire);

`ifdef ARB_RR_EN
    logic r_last_d;

    always_ff @(posedge clk) begin
        if (rst)
            r_last_d <= 1'b0;
        else if (w_grant_d)
            r_last_d <= 1'b1;
        else if (w_grant_i)
            r_last_d <= 1'b0;
    end

    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == S_IDLE) begin
            w_grant_d = d_strobe & (~i_strobe | ~r_last_d);
            w_grant_i = i_strobe & ~w_grant_d;
        end
    end
`else
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == S_IDLE) begin
            w_grant_d = d_strobe;
            w_grant_i = i_strobe & ~d_strobe;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d)
                    w_next = S_BUSY_D;
                else if (w_grant_i)
                    w_next = S_BUSY_I;
            end
            S_BUSY_I, S_BUSY_D: begin
                if (w_done)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_m_a      <= '0;
            r_m_din    <= '0;
            r_m_wen    <= '0;
            r_m_size   <= '0;
            r_m_rw     <= 1'b0;
            r_m_strobe <= 1'b0;
            r_bus_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if (w_expire)
                r_bus_err <= 1'b1;
            if (w_grant_d) begin
                r_m_a      <= d_a;
                r_m_din    <= d_dout;
                r_m_wen    <= d_wen;
                r_m_size   <= d_size;
                r_m_rw     <= d_rw;
                r_m_strobe <= 1'b1;
                r_cnt      <= '0;
            end else if (w_grant_i) begin
                r_m_a      <= i_a;
                r_m_din    <= '0;
                r_m_wen    <= 4'b0000;
                r_m_size   <= 2'b10;
                r_m_rw     <= 1'b0;
                r_m_strobe <= 1'b1;
                r_cnt      <= '0;
            end else if (w_done) begin
                r_m_strobe <= 1'b0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // A reset landing mid-transaction must not let a late m_ready leak out as a completion
    assign i_ready  = (r_state == S_BUSY_I) & w_done & ~rst;
    assign d_ready  = (r_state == S_BUSY_D) & w_done & ~rst;
    assign i_din    = (r_state == S_BUSY_I) ? (w_expire ? 32'hFFFF_FFFF : m_dout) : 32'h0;
    assign d_din    = (r_state == S_BUSY_D) ? (w_expire ? 32'hFFFF_FFFF : m_dout) : 32'h0;

    assign m_a      = r_m_a;
    assign m_din    = r_m_din;
    assign m_wen    = r_m_wen;
    assign m_size   = r_m_size;
    assign m_rw     = r_m_rw;
    assign m_strobe = r_m_strobe;
    assign bus_err  = r_bus_err;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: lone I read, D write, ties, watchdog, back-to-back, reset abort.
// Inputs change and outputs are checked 1 ns after each rising edge.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_a;
    logic        i_strobe;
    logic [31:0] i_din;
    logic        i_ready;
    logic [31:0] d_a;
    logic [31:0] d_dout;
    logic [3:0]  d_wen;
    logic [1:0]  d_size;
    logic        d_rw;
    logic        d_strobe;
    logic [31:0] d_din;
    logic        d_ready;
    logic [31:0] m_a;
    logic [31:0] m_din;
    logic [3:0]  m_wen;
    logic [1:0]  m_size;
    logic        m_rw;
    logic        m_strobe;
    logic [31:0] m_dout;
    logic        m_ready;
    logic        bus_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.A_WIDTH(32), .TO_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_a(i_a), .i_strobe(i_strobe), .i_din(i_din), .i_ready(i_ready),
        .d_a(d_a), .d_dout(d_dout), .d_wen(d_wen), .d_size(d_size), .d_rw(d_rw),
        .d_strobe(d_strobe), .d_din(d_din), .d_ready(d_ready),
        .m_a(m_a), .m_din(m_din), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
        .m_strobe(m_strobe), .m_dout(m_dout), .m_ready(m_ready), .bus_err(bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic exp_d;

    initial begin
        rst = 1'b1; i_a = '0; i_strobe = 1'b0;
        d_a = '0; d_dout = '0; d_wen = '0; d_size = '0; d_rw = 1'b0; d_strobe = 1'b0;
        m_dout = '0; m_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_m_strobe", {31'b0, m_strobe}, 32'd0);
        check("rst_m_a", m_a, 32'd0);
        check("rst_m_wen", {28'b0, m_wen}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        check("rst_i_ready", {31'b0, i_ready}, 32'd0);
        check("rst_d_din", d_din, 32'd0);

        // 1: lone I read
        i_a = 32'h1FC0_0000; i_strobe = 1'b1;
        tick();
        check("t1_m_strobe", {31'b0, m_strobe}, 32'd1);
        check("t1_m_a", m_a, 32'h1FC0_0000);
        check("t1_m_rw", {31'b0, m_rw}, 32'd0);
        check("t1_m_size", {30'b0, m_size}, 32'd2);
        check("t1_m_wen", {28'b0, m_wen}, 32'd0);
        check("t1_i_ready_early", {31'b0, i_ready}, 32'd0);
        tick();
        tick();
        m_ready = 1'b1; m_dout = 32'h2408_0001;
        #1;
        check("t1_i_ready", {31'b0, i_ready}, 32'd1);
        check("t1_i_din", i_din, 32'h2408_0001);
        check("t1_d_ready", {31'b0, d_ready}, 32'd0);
        check("t1_d_din", d_din, 32'd0);
        tick();
        i_strobe = 1'b0; m_ready = 1'b0;
        #1;
        check("t1_m_strobe_drop", {31'b0, m_strobe}, 32'd0);
        check("t1_i_ready_once", {31'b0, i_ready}, 32'd0);

        // 2: D write, inputs wander during BUSY
        d_a = 32'h0000_1004; d_dout = 32'hAABB_CCDD; d_wen = 4'b1100; d_size = 2'b10;
        d_rw = 1'b1; d_strobe = 1'b1;
        tick();
        check("t2_m_strobe", {31'b0, m_strobe}, 32'd1);
        check("t2_m_a", m_a, 32'h0000_1004);
        check("t2_m_din", m_din, 32'hAABB_CCDD);
        check("t2_m_wen", {28'b0, m_wen}, 32'hC);
        check("t2_m_rw", {31'b0, m_rw}, 32'd1);
        d_a = 32'hDEAD_0000; d_dout = 32'h1111_2222; d_wen = 4'b0001;
        tick();
        check("t2_m_a_stable", m_a, 32'h0000_1004);
        check("t2_m_din_stable", m_din, 32'hAABB_CCDD);
        check("t2_m_wen_stable", {28'b0, m_wen}, 32'hC);
        m_ready = 1'b1; m_dout = 32'h0;
        #1;
        check("t2_d_ready", {31'b0, d_ready}, 32'd1);
        check("t2_i_ready", {31'b0, i_ready}, 32'd0);
        tick();
        d_strobe = 1'b0; m_ready = 1'b0; d_rw = 1'b0;
        #1;
        check("t2_m_strobe_drop", {31'b0, m_strobe}, 32'd0);

        // 3: four ties from a fresh reset
        do_reset();
        d_a = 32'h0000_2000; i_a = 32'h0000_3000;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            i_strobe = 1'b1; d_strobe = 1'b1;
            tick();
            check($sformatf("t3_m_a_%0d", k), m_a, exp_d ? 32'h0000_2000 : 32'h0000_3000);
            m_ready = 1'b1; m_dout = 32'h5A5A_0000 + k;
            #1;
            check($sformatf("t3_d_ready_%0d", k), {31'b0, d_ready}, {31'b0, exp_d});
            check($sformatf("t3_i_ready_%0d", k), {31'b0, i_ready}, {31'b0, ~exp_d});
            tick();
            i_strobe = 1'b0; d_strobe = 1'b0; m_ready = 1'b0;
            #1;
            check($sformatf("t3_idle_%0d", k), {31'b0, m_strobe}, 32'd0);
        end

        // 4: hung slave, TO_CYCLES=8
        d_a = 32'h0000_4000; d_rw = 1'b0; d_strobe = 1'b1; m_dout = 32'h1234_5678;
        tick();
        for (int k = 1; k < 8; k++) begin
            check($sformatf("t4_no_ready_c%0d", k), {31'b0, d_ready}, 32'd0);
            tick();
        end
        check("t4_d_ready_c8", {31'b0, d_ready}, 32'd1);
        check("t4_d_din_c8", d_din, 32'hFFFF_FFFF);
        check("t4_i_ready_c8", {31'b0, i_ready}, 32'd0);
        check("t4_bus_err_pre", {31'b0, bus_err}, 32'd0);
        tick();
        d_strobe = 1'b0;
        #1;
        check("t4_bus_err", {31'b0, bus_err}, 32'd1);
        check("t4_m_strobe", {31'b0, m_strobe}, 32'd0);
        check("t4_d_ready_after", {31'b0, d_ready}, 32'd0);

        // 6: back-to-back D with strobe held through ready and the IDLE cycle
        d_a = 32'h0000_0100; d_rw = 1'b1; d_strobe = 1'b1;
        tick();
        check("t6_first_m_a", m_a, 32'h0000_0100);
        m_ready = 1'b1;
        #1;
        check("t6_first_ready", {31'b0, d_ready}, 32'd1);
        tick();
        m_ready = 1'b0; d_a = 32'h0000_0200;
        #1;
        check("t6_idle_gap", {31'b0, m_strobe}, 32'd0);
        check("t6_idle_ready", {31'b0, d_ready}, 32'd0);
        tick();
        check("t6_second_strobe", {31'b0, m_strobe}, 32'd1);
        check("t6_second_m_a", m_a, 32'h0000_0200);
        m_ready = 1'b1;
        #1;
        check("t6_second_ready", {31'b0, d_ready}, 32'd1);
        tick();
        d_strobe = 1'b0; m_ready = 1'b0;
        #1;
        check("t6_bus_err_sticky", {31'b0, bus_err}, 32'd1);

        // 5: reset two cycles into an I grant
        i_a = 32'h0000_5000; i_strobe = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t5_i_ready_in_rst", {31'b0, i_ready}, 32'd0);
        tick();
        check("t5_m_strobe", {31'b0, m_strobe}, 32'd0);
        check("t5_bus_err", {31'b0, bus_err}, 32'd0);
        check("t5_i_ready", {31'b0, i_ready}, 32'd0);
        rst = 1'b0; i_strobe = 1'b0;
        tick();
        check("t5_idle", {31'b0, m_strobe}, 32'd0);
        i_a = 32'h0000_6000; i_strobe = 1'b1;
        tick();
        check("t5_regrant_m_a", m_a, 32'h0000_6000);
        m_ready = 1'b1; m_dout = 32'hCAFE_0001;
        #1;
        check("t5_regrant_ready", {31'b0, i_ready}, 32'd1);
        check("t5_regrant_din", i_din, 32'hCAFE_0001);
        tick();
        i_strobe = 1'b0; m_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
